// File: rtl/adder_4bit.sv
// Ripple-carry adder with a load-enabled result register.
// S/Co are purely combinational; q captures S on a rising clk when en is high.
`timescale 1ns/1ps
module adder_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] q,
  output logic             Co
);

  logic [WIDTH:0] carry;

  assign carry[0] = Cin;

  // One full-adder cell per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
    assign S[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Co = carry[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= S;
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
// Directed-vector bench for adder_4bit: combinational sum/carry plus the
// enable and asynchronous-reset behaviour of the result register.
`timescale 1ns/1ps
module tb_adder_4bit;

  localparam int unsigned WIDTH = 4;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             clk;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] q;
  logic             Co;

  int unsigned vectors;
  int unsigned miscompares;

  adder_4bit #(.WIDTH(WIDTH)) dut (
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .S    (S),
    .q    (q),
    .Co   (Co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    A   = a;
    B   = b;
    Cin = c;
    #1;
  endtask

  // Combinational-only vectors: {A, B, Cin, expected S, expected Co}
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] s;
    logic       co;
  } vec_t;

  vec_t comb_vecs[5];

  initial begin
    vectors     = 0;
    miscompares = 0;

    comb_vecs[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    comb_vecs[1] = '{4'h8, 4'h8, 1'b1, 4'h1, 1'b1};
    comb_vecs[2] = '{4'h5, 4'hA, 1'b0, 4'hF, 1'b0};
    comb_vecs[3] = '{4'h5, 4'hA, 1'b1, 4'h0, 1'b1};
    comb_vecs[4] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};

    // 1: reset held from t=0, overflowing operands
    reset = 1'b1;
    en    = 1'b0;
    drive(4'hF, 4'hF, 1'b0);
    check("rst_q",  8'(q),  8'h00);
    check("rst_s",  8'(S),  8'h0E);
    check("rst_co", 8'(Co), 8'h01);
    after_edge();
    after_edge();
    check("rst_q_held", 8'(q), 8'h00);

    // 2: release reset mid-cycle, first edge loads the sum
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    #1;
    check("rel_q_pre", 8'(q), 8'h00);
    after_edge();
    check("load_q",  8'(q),  8'h0E);
    check("load_co", 8'(Co), 8'h01);

    // 3: small sum, S immediate, q one edge later
    @(negedge clk);
    drive(4'h1, 4'h1, 1'b0);
    check("s_0010",  8'(S),  8'h02);
    check("co_0010", 8'(Co), 8'h00);
    check("q_pre",   8'(q),  8'h0E);
    after_edge();
    check("q_0010",  8'(q),  8'h02);

    // 4: carry-in ripples through the chain
    @(negedge clk);
    drive(4'h6, 4'h1, 1'b0);
    check("s_0111", 8'(S), 8'h07);
    after_edge();
    check("q_0111", 8'(q), 8'h07);
    @(negedge clk);
    drive(4'h6, 4'h1, 1'b1);
    check("s_1000",  8'(S),  8'h08);
    check("co_1000", 8'(Co), 8'h00);
    after_edge();
    check("q_1000", 8'(q), 8'h08);

    // 5: en low holds q while S keeps tracking
    @(negedge clk);
    en = 1'b0;
    drive(4'h3, 4'h4, 1'b0);
    check("hold_s", 8'(S), 8'h07);
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("hold_q", 8'(q), 8'h08);
    end

    // 6: async reset between edges dominates en
    @(negedge clk);
    en    = 1'b1;
    reset = 1'b1;
    #1;
    check("async_q", 8'(q), 8'h00);
    after_edge();
    check("async_q_held", 8'(q), 8'h00);
    drive(4'hF, 4'h0, 1'b1);
    check("rst_track_s",  8'(S),  8'h00);
    check("rst_track_co", 8'(Co), 8'h01);

    // Release mid-cycle: no effect until the following edge
    @(negedge clk);
    drive(4'h3, 4'h4, 1'b0);
    reset = 1'b0;
    #1;
    check("rel2_q_pre", 8'(q), 8'h00);
    after_edge();
    check("rel2_q", 8'(q), 8'h07);

    // Extra boundary vectors on the combinational path
    en = 1'b0;
    foreach (comb_vecs[i]) begin
      drive(comb_vecs[i].a, comb_vecs[i].b, comb_vecs[i].c);
      check("vec_s",  8'(S),  8'(comb_vecs[i].s));
      check("vec_co", 8'(Co), 8'(comb_vecs[i].co));
    end
    check("vec_q_hold", 8'(q), 8'h07);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
